// File: rtl/bcd_gate_counter.sv
// Gated N-digit BCD event counter with snapshot latch, carry pulse and sticky overflow.
// Define BCD_GATE_COUNTER_DOWN_EN to add the UD port for up/down counting.
module bcd_gate_counter #(
    parameter int DIGITS  = 6,
    parameter int LAT_RST = 0
) (
    input  logic                F_IN,
    input  logic                CLR_N,
    input  logic                EN,
    input  logic                SCLR,
    input  logic                LATCH,
`ifdef BCD_GATE_COUNTER_DOWN_EN
    input  logic                UD,
`endif
    output logic [4*DIGITS-1:0] Q,
    output logic [4*DIGITS-1:0] Q_LAT,
    output logic                CO,
    output logic                OVF
);

    localparam int         W       = 4*DIGITS;
    localparam logic [3:0] LAT_NIB = 4'(LAT_RST);

    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  lat_q, lat_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;
    logic [DIGITS:0] nines;
    logic          up;

`ifdef BCD_GATE_COUNTER_DOWN_EN
    logic [DIGITS:0] zeros;

    assign up = UD;

    // Borrow chain: digit k moves only when every lower digit is 0
    always_comb begin
        zeros[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            zeros[k+1] = zeros[k] & (q_q[4*k +: 4] == 4'd0);
        end
    end
`else
    assign up = 1'b1;
`endif

    // Carry chain: digit k moves only when every lower digit is 9
    always_comb begin
        nines[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            nines[k+1] = nines[k] & (q_q[4*k +: 4] == 4'd9);
        end
    end

    always_comb begin
        q_d   = q_q;
        co_d  = 1'b0;
        ovf_d = ovf_q;
        lat_d = LATCH ? q_q : lat_q;
        if (SCLR) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (EN) begin
            if (up) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (nines[k]) begin
                        q_d[4*k +: 4] = (q_q[4*k +: 4] == 4'd9) ?
                                        4'd0 : q_q[4*k +: 4] + 4'd1;
                    end
                end
                if (nines[DIGITS]) begin
                    co_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end
`ifdef BCD_GATE_COUNTER_DOWN_EN
            else begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (zeros[k]) begin
                        q_d[4*k +: 4] = (q_q[4*k +: 4] == 4'd0) ?
                                        4'd9 : q_q[4*k +: 4] - 4'd1;
                    end
                end
                if (zeros[DIGITS]) begin
                    co_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge F_IN or negedge CLR_N) begin
        if (!CLR_N) begin
            q_q   <= '0;
            lat_q <= {DIGITS{LAT_NIB}};
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            lat_q <= lat_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q     = q_q;
    assign Q_LAT = lat_q;
    assign CO    = co_q;
    assign OVF   = ovf_q;

endmodule
